// File: rtl/vectored_mac_stream.sv
// rtl/vectored_mac_stream.sv - multi-lane pipelined dot-product MAC with valid/ready stream ports
// Stage 1 registers per-lane products; stage 2 accumulates and emits one result per vector.
module vectored_mac_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int VEC_LEN    = 4,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
  parameter int SIGNED     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Clr,
  input  logic [LANES*DATA_WIDTH-1:0]  Ain,
  input  logic [LANES*DATA_WIDTH-1:0]  Bin,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES*ACC_WIDTH-1:0]   Cout,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(VEC_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(VEC_LEN - 1);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_last_q, s1_last_d;
  logic [LANES*PW-1:0]        prod_q, prod_d;
  logic [LANES*ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LANES*ACC_WIDTH-1:0] cout_q, cout_d;
  logic                       out_valid_q, out_valid_d;
  logic [LANES*ACC_WIDTH-1:0] sum;
  logic                       stall;
  logic                       accept;

  // One extra operand bit makes a single signed multiplier serve both modes.
  function automatic logic [PW-1:0] mul(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH:0] ax;
    logic signed [DATA_WIDTH:0] bx;
    logic signed [PW+1:0]       p;
    ax = {(SIGNED != 0) & a[DATA_WIDTH-1], a};
    bx = {(SIGNED != 0) & b[DATA_WIDTH-1], b};
    p  = (PW+2)'(ax) * (PW+2)'(bx);
    return p[PW-1:0];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] ext(input logic [PW-1:0] p);
    return {{(ACC_WIDTH-PW){(SIGNED != 0) & p[PW-1]}}, p};
  endfunction

  always_comb begin
    stall       = out_valid_q && !out_ready;
    in_ready    = !Clr && !stall;
    accept      = in_valid && in_ready;
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q && !out_ready;
    sum         = '0;
    for (int i = 0; i < LANES; i++) begin
      sum[i*ACC_WIDTH +: ACC_WIDTH] = acc_q[i*ACC_WIDTH +: ACC_WIDTH] + ext(prod_q[i*PW +: PW]);
    end

    // A pending output survives Clr; only the in-progress vector is dropped.
    if (Clr) begin
      cnt_d      = '0;
      s1_valid_d = 1'b0;
      acc_d      = '0;
    end else if (!stall) begin
      s1_valid_d = accept;
      s1_last_d  = (cnt_q == LAST_CNT);
      if (accept) begin
        cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        for (int i = 0; i < LANES; i++) begin
          prod_d[i*PW +: PW] = mul(Ain[i*DATA_WIDTH +: DATA_WIDTH], Bin[i*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
      if (s1_valid_q) begin
        if (s1_last_q) begin
          cout_d      = sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      cout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/vectored_mac_stream.md
# vectored_mac_stream

Parametrised, pipelined multi-lane multiply-accumulate engine. It consumes a stream of packed A/B operand beats through a valid/ready handshake, accumulates a dot product per lane over a fixed vector length, and emits one packed result word per completed vector through a valid/ready output. It is the successor to the single-lane enable/clear MAC and sits between the operand FIFOs and the result FIFO of the MAC datapath.

## Interface
- DATA_WIDTH, 8: width of each operand element
- LANES, 2: number of independent MAC lanes
- VEC_LEN, 4: beats per vector (≥2); one result per VEC_LEN accepted beats
- ACC_WIDTH, 3*DATA_WIDTH: per-lane accumulator and result width
- SIGNED, 0: 0 = unsigned operands, 1 = two's-complement operands
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- Clr  input  1  synchronous clear of in-progress vector
- Ain  input  LANES*DATA_WIDTH  packed A operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- Bin  input  LANES*DATA_WIDTH  packed B operands, same packing
- in_valid  input  1  Ain/Bin beat valid
- in_ready  output  1  engine accepts a beat this cycle
- Cout  output  LANES*ACC_WIDTH  packed per-lane results, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
- out_valid  output  1  Cout holds an unconsumed result
- out_ready  input  1  downstream consumes Cout

## Operation
- Beat accepted on a rising edge with in_valid && in_ready.
- Stage 1 (multiply): per lane, product A*B (2*DATA_WIDTH bits, signed or unsigned per SIGNED) registered with a stage-valid bit and a last flag.
- Beat counter (0..VEC_LEN-1) increments on acceptance; last = (count == VEC_LEN-1); counter wraps to 0 after the last beat.
- Stage 2 (accumulate): product extended to ACC_WIDTH (sign-extended if SIGNED=1, zero-extended otherwise) and added to the lane accumulator, modulo 2^ACC_WIDTH (wrap, no saturation).
- On a last beat in stage 2: Cout <= acc + ext(product) for every lane, accumulators <= 0, out_valid <= 1. No bubble between vectors.
- Output handshake: Cout and out_valid held stable until out_valid && out_ready. On consumption with no new result, out_valid <= 0 and Cout holds its value. On consumption with a simultaneous new result, Cout loads the new value and out_valid stays 1.
- Stall: stall = out_valid && !out_ready. During stall both stages, the counter and the accumulators freeze; in_ready = 0.
- in_ready = !Clr && !stall (combinational).
- Clr (sync): clears accumulators, beat counter and stage-1 valid. A beat presented with Clr is not accepted. A pending output (out_valid, Cout) is unaffected by Clr.
- rst_n low (async): all state cleared immediately, including a vector in progress.

## Timing
- Reset values: Cout = 0, out_valid = 0; in_ready = 1 once rst_n is high and Clr is low.
- Latency: last beat accepted at edge N → out_valid = 1 and Cout valid after edge N+1.
- Throughput: one beat per cycle; one result per VEC_LEN cycles when out_ready stays high.
- out_ready low while out_valid = 1: in_ready falls in the same cycle. The beat already in stage 1 holds until the stall releases, then proceeds.
- Clr and rst_n take precedence over all handshakes. Clr in a cycle where a last beat sits in stage 1 discards that beat; no result is produced.

## Test plan
- Reset: hold rst_n low with in_valid=1 → Cout=0, out_valid=0. Release with Clr=0 → in_ready=1 next cycle.
- Unsigned dot product (defaults): lane0 A=1,2,3,4 with B=2; lane1 A=B=255 for 4 beats, back-to-back → out_valid 2 edges after the 4th acceptance; lane0=20 (0x000014), lane1=260100 (0x03F804).
- Backpressure: out_ready=0 while streaming a second vector → in_ready drops when the first result's out_valid rises; Cout stays stable. Raise out_ready → first result consumed, second vector completes with the correct sums and no lost or duplicated beats.
- Clr mid-vector: 2 beats of A=B=9, then a Clr pulse, then 4 beats of A=B=1 → both lanes = 4; the earlier beats are not included.
- Signed mode (SIGNED=1): A=-128, B=127 for 4 beats on both lanes → each lane = 0xFF0200 (-65024).
- Async reset mid-vector: rst_n low after 2 beats → outputs go to 0 without waiting for a clock edge. The next full vector of A=3, B=5 gives 60 on each lane.
